fp32_sub_seq: RTL



---
 rtl/fp32_pkg.sv | 28 ++
 rtl/fp32_unpack.sv | 36 +++
 rtl/fp32_sub_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared definitions for the sequential fp32 datapath blocks.
//   state_t        : controller states of fp32_sub_seq
//   fp_unpacked_t  : operand split into sign, biased exponent and 24-bit
//                    mantissa with the hidden bit restored
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SUB,
    S_NORM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
  } fp_unpacked_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational field split of an IEEE-754 single.
//   word      : packed operand
//   op        : sign, biased exponent, mantissa with hidden bit restored
//   is_zero   : exponent field is 0 (denormals are flushed to zero here)
//   is_infnan : exponent field is all ones (infinity or NaN)
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]  word,
  output fp_unpacked_t op,
  output logic         is_zero,
  output logic         is_infnan
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac;

  assign exp_f     = word[MAN_W +: EXP_W];
  assign frac      = word[MAN_W-1:0];
  assign is_zero   = (exp_f == '0);
  assign is_infnan = (exp_f == '1);

  // NOTE: every field gets a value on every path, so no latch can be inferred.
  always_comb begin
    op.sign = word[31];
    if (is_zero) begin
      // Denormal or zero: treated as an exact zero of the same sign.
      op.exp  = '0;
      op.mant = '0;
    end else begin
      op.exp  = exp_f;
      op.mant = {1'b1, frac};
    end
  end

endmodule

// File: rtl/fp32_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: result = num1 - num2.
// Truncating (round toward zero), no denormals, NaN/Inf inputs give a quiet NaN.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   num1, num2          : minuend, subtrahend
//   out_valid/out_ready : result handshake (result held until taken)
//   result, overflow    : difference; overflow set when exponent saturates
// Latency from accept: ALIGN, SUB, then one NORM cycle per left shift plus
// the packing cycle, i.e. 3 + k cycles for a normal result.
module fp32_sub_seq
  import fp32_pkg::*;
#(
  parameter int ALIGN_LIMIT = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow
);

  state_t state_q, state_d;

  logic [31:0] a_q, a_d, b_q, b_d;      // operands, b already negated
  logic        sign_q, sign_d;
  logic        same_q, same_d;          // effective operation is an add
  logic [7:0]  exp_q, exp_d;
  logic [23:0] mant_q, mant_d;          // larger / working mantissa
  logic [23:0] small_q, small_d;        // aligned smaller mantissa
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;

  // Operand decode and magnitude ordering (used in ALIGN)
  fp_unpacked_t ua, ub;
  logic         a_zero, b_zero, a_nan, b_nan;
  logic         a_ge;
  logic         big_sign;
  logic [7:0]   big_exp, small_exp, diff;
  logic [23:0]  big_mant, small_mant, small_sh;

  fp32_unpack u_unpack_a (.word(a_q), .op(ua), .is_zero(a_zero), .is_infnan(a_nan));
  fp32_unpack u_unpack_b (.word(b_q), .op(ub), .is_zero(b_zero), .is_infnan(b_nan));

  assign a_ge       = (ua.exp > ub.exp) || ((ua.exp == ub.exp) && (ua.mant >= ub.mant));
  assign big_sign   = a_ge ? ua.sign : ub.sign;
  assign big_exp    = a_ge ? ua.exp  : ub.exp;
  assign big_mant   = a_ge ? ua.mant : ub.mant;
  assign small_exp  = a_ge ? ub.exp  : ua.exp;
  assign small_mant = a_ge ? ub.mant : ua.mant;
  assign diff       = big_exp - small_exp;
  // Shifted-out bits are dropped; large gaps flush the smaller operand.
  assign small_sh   = (diff >= 8'(ALIGN_LIMIT)) ? '0 : (small_mant >> diff);

  // Add / subtract (used in SUB)
  logic [24:0] sum;
  logic [23:0] mant_s;
  logic [8:0]  exp_s;

  assign sum    = {1'b0, mant_q} + {1'b0, small_q};
  assign mant_s = same_q ? (sum[24] ? sum[24:1] : sum[23:0]) : (mant_q - small_q);
  assign exp_s  = same_q ? ({1'b0, exp_q} + {8'd0, sum[24]}) : {1'b0, exp_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    same_d  = same_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    small_d = small_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = num1;
          b_d     = {~num2[31], num2[30:0]};
          state_d = S_ALIGN;
        end
      end

      S_ALIGN: begin
        ovf_d = 1'b0;
        if (a_nan || b_nan) begin
          res_d   = QNAN;
          state_d = S_DONE;
        end else if (a_zero && b_zero) begin
          res_d   = 32'h0;
          state_d = S_DONE;
        end else begin
          sign_d  = big_sign;
          same_d  = (ua.sign == ub.sign);
          exp_d   = big_exp;
          mant_d  = big_mant;
          small_d = small_sh;
          state_d = S_SUB;
        end
      end

      S_SUB: begin
        if (mant_s == '0) begin
          res_d   = 32'h0;
          state_d = S_DONE;
        end else if (exp_s >= 9'(EXP_MAX)) begin
          res_d   = {sign_q, 8'hFF, 23'h0};
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          mant_d  = mant_s;
          exp_d   = exp_s[7:0];
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (mant_q[23]) begin
          res_d   = {sign_q, exp_q, mant_q[22:0]};
          state_d = S_DONE;
        end else if (exp_q > 8'd1) begin
          mant_d = {mant_q[22:0], 1'b0};
          exp_d  = exp_q - 8'd1;
        end else begin
          // Another shift would need exponent 0: underflow to signed zero.
          res_d   = {sign_q, 31'h0};
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values computed before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      same_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      small_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      same_q  <= same_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      small_q <= small_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign overflow  = ovf_q;

endmodule
